// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic/compare ops, plus a W-cycle shift-add
// unsigned multiplier. Results and flags are registered and announced by a one-cycle OUT_VALID.
module alu_seq #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] DATA_A,
  input  logic [W-1:0] DATA_B,
  input  logic [2:0]   control,
  input  logic         IN_VALID,
  output logic         IN_READY,
  output logic [W-1:0] OUT,
  output logic         OUT_VALID,
  output logic         CO,
  output logic         OVF,
  output logic         N,
  output logic         Z
);
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_ADC = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic {S_IDLE, S_MULT} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a, r_b;
  logic [2:0]      r_op;
  logic            r_go;
  logic [2*W-1:0]  r_prod;
  logic [CW-1:0]   r_cnt;

  logic [W-1:0]    w_opb;
  logic            w_cin;
  logic [W:0]      w_sum;
  logic            w_add_ovf;
  logic [W-1:0]    w_res;
  logic            w_co, w_ovf;
  logic [W:0]      w_acc;
  logic [2*W-1:0]  w_prod_nxt;

  assign IN_READY = (r_state == S_IDLE);

  // One adder serves ADD/SUB/ADC/CMP; subtraction is A + ~B + 1.
  always_comb begin
    w_opb = r_b;
    w_cin = 1'b0;
    case (r_op)
      OP_SUB, OP_CMP: begin w_opb = ~r_b; w_cin = 1'b1; end
      OP_ADC:         w_cin = CO;
      default: ;
    endcase
  end

  assign w_sum     = {1'b0, r_a} + {1'b0, w_opb} + {{W{1'b0}}, w_cin};
  assign w_add_ovf = (r_a[W-1] == w_opb[W-1]) && (w_sum[W-1] != r_a[W-1]);

  always_comb begin
    w_res = w_sum[W-1:0];
    w_co  = w_sum[W];
    w_ovf = w_add_ovf;
    case (r_op)
      OP_AND: begin w_res = r_a & r_b; w_co = 1'b0; w_ovf = 1'b0; end
      OP_ORR: begin w_res = r_a | r_b; w_co = 1'b0; w_ovf = 1'b0; end
      OP_XOR: begin w_res = r_a ^ r_b; w_co = 1'b0; w_ovf = 1'b0; end
      default: ;
    endcase
  end

  // Product register holds {partial high, remaining multiplier bits}; one bit retired per cycle.
  assign w_acc      = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_a} : {(W+1){1'b0}});
  assign w_prod_nxt = {w_acc, r_prod[W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= OP_ADD;
      r_go      <= 1'b0;
      r_prod    <= '0;
      r_cnt     <= '0;
      OUT       <= '0;
      OUT_VALID <= 1'b0;
      CO        <= 1'b0;
      OVF       <= 1'b0;
      N         <= 1'b0;
      Z         <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      r_go      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_go) begin
            if (r_op != OP_CMP) OUT <= w_res;
            CO        <= w_co;
            OVF       <= w_ovf;
            N         <= w_res[W-1];
            Z         <= (w_res == '0);
            OUT_VALID <= 1'b1;
          end
          if (IN_VALID) begin
            r_a  <= DATA_A;
            r_b  <= DATA_B;
            r_op <= control;
            if (control == OP_MUL) begin
              r_prod  <= {{W{1'b0}}, DATA_B};
              r_cnt   <= CNT_LOAD;
              r_state <= S_MULT;
            end else begin
              r_go <= 1'b1;
            end
          end
        end
        S_MULT: begin
          r_prod <= w_prod_nxt;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            OUT       <= w_prod_nxt[W-1:0];
            CO        <= 1'b0;
            OVF       <= |w_prod_nxt[2*W-1:W];
            N         <= w_prod_nxt[W-1];
            Z         <= (w_prod_nxt[W-1:0] == '0);
            OUT_VALID <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at W=12; results are sampled 1ns after the rising edge.
module tb_alu_seq;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] DATA_A, DATA_B;
  logic [2:0]   control;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] OUT;
  logic         OUT_VALID;
  logic         CO, OVF, N, Z;

  int total = 0;
  int bad   = 0;

  alu_seq #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .DATA_A(DATA_A), .DATA_B(DATA_B), .control(control),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .OUT(OUT), .OUT_VALID(OUT_VALID),
    .CO(CO), .OVF(OVF), .N(N), .Z(Z)
  );

  always #5 clk = ~clk;

  // Drive one request; returns 1ns after the accepting edge with IN_VALID dropped.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    @(negedge clk);
    DATA_A = a; DATA_B = b; control = op; IN_VALID = 1'b1;
    @(posedge clk); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; IN_VALID = 1'b0; DATA_A = '0; DATA_B = '0; control = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({OUT, OUT_VALID, CO, OVF, N, Z, IN_READY} !== {12'h000, 6'b000001}) begin
      bad++; $display("FAIL reset_state got=%h req=%h", {OUT, OUT_VALID, CO, OVF, N, Z, IN_READY}, {12'h000, 6'b000001});
    end
    @(negedge clk);
    rst_n = 1'b1; DATA_A = 12'h003; DATA_B = 12'h004; control = 3'b000; IN_VALID = 1'b1;
    @(posedge clk); #1;
    IN_VALID = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({OUT_VALID, OUT} !== {1'b1, 12'h007}) begin
      bad++; $display("FAIL first_accept got=%h req=%h", {OUT_VALID, OUT}, {1'b1, 12'h007});
    end
  endtask

  task automatic test_add;
    issue(12'h800, 12'h800, 3'b000);
    @(posedge clk); #1;
    total++;
    if ({OUT_VALID, OUT, CO, OVF, N, Z} !== {1'b1, 12'h000, 4'b1101}) begin
      bad++; $display("FAIL add_ovf got=%h req=%h", {OUT_VALID, OUT, CO, OVF, N, Z}, {1'b1, 12'h000, 4'b1101});
    end
    @(posedge clk); #1;
    total++;
    if ({OUT_VALID, OUT, CO, OVF, N, Z} !== {1'b0, 12'h000, 4'b1101}) begin
      bad++; $display("FAIL add_hold got=%h req=%h", {OUT_VALID, OUT, CO, OVF, N, Z}, {1'b0, 12'h000, 4'b1101});
    end
  endtask

  task automatic test_sub_adc;
    issue(12'h005, 12'h007, 3'b001);
    @(posedge clk); #1;
    total++;
    if ({OUT_VALID, OUT, CO, OVF, N, Z} !== {1'b1, 12'hFFE, 4'b0010}) begin
      bad++; $display("FAIL sub got=%h req=%h", {OUT_VALID, OUT, CO, OVF, N, Z}, {1'b1, 12'hFFE, 4'b0010});
    end
    issue(12'h001, 12'h001, 3'b101);
    @(posedge clk); #1;
    total++;
    if ({OUT_VALID, OUT, CO, OVF, N, Z} !== {1'b1, 12'h002, 4'b0000}) begin
      bad++; $display("FAIL adc_c0 got=%h req=%h", {OUT_VALID, OUT, CO, OVF, N, Z}, {1'b1, 12'h002, 4'b0000});
    end
    issue(12'hFFF, 12'h001, 3'b000);
    @(posedge clk); #1;
    total++;
    if ({OUT, CO, OVF, N, Z} !== {12'h000, 4'b1001}) begin
      bad++; $display("FAIL add_carry got=%h req=%h", {OUT, CO, OVF, N, Z}, {12'h000, 4'b1001});
    end
    issue(12'h001, 12'h001, 3'b101);
    @(posedge clk); #1;
    total++;
    if ({OUT_VALID, OUT, CO, OVF, N, Z} !== {1'b1, 12'h003, 4'b0000}) begin
      bad++; $display("FAIL adc_c1 got=%h req=%h", {OUT_VALID, OUT, CO, OVF, N, Z}, {1'b1, 12'h003, 4'b0000});
    end
  endtask

  task automatic test_cmp;
    issue(12'h100, 12'h023, 3'b000);
    @(posedge clk); #1;
    total++;
    if (OUT !== 12'h123) begin
      bad++; $display("FAIL cmp_setup got=%h req=%h", OUT, 12'h123);
    end
    issue(12'h010, 12'h010, 3'b111);
    @(posedge clk); #1;
    total++;
    if ({OUT_VALID, OUT, CO, OVF, N, Z} !== {1'b1, 12'h123, 4'b1001}) begin
      bad++; $display("FAIL cmp got=%h req=%h", {OUT_VALID, OUT, CO, OVF, N, Z}, {1'b1, 12'h123, 4'b1001});
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    DATA_A = 12'hF0F; DATA_B = 12'h0FF; control = 3'b010; IN_VALID = 1'b1;
    @(posedge clk); #1;
    control = 3'b011;
    @(posedge clk); #1;
    total++;
    if ({OUT_VALID, OUT, CO, OVF, N, Z} !== {1'b1, 12'h00F, 4'b0000}) begin
      bad++; $display("FAIL b2b_and got=%h req=%h", {OUT_VALID, OUT, CO, OVF, N, Z}, {1'b1, 12'h00F, 4'b0000});
    end
    control = 3'b100;
    @(posedge clk); #1;
    IN_VALID = 1'b0;
    total++;
    if ({OUT_VALID, OUT, CO, OVF, N, Z} !== {1'b1, 12'hFFF, 4'b0010}) begin
      bad++; $display("FAIL b2b_orr got=%h req=%h", {OUT_VALID, OUT, CO, OVF, N, Z}, {1'b1, 12'hFFF, 4'b0010});
    end
    @(posedge clk); #1;
    total++;
    if ({OUT_VALID, OUT, CO, OVF, N, Z} !== {1'b1, 12'hFF0, 4'b0010}) begin
      bad++; $display("FAIL b2b_xor got=%h req=%h", {OUT_VALID, OUT, CO, OVF, N, Z}, {1'b1, 12'hFF0, 4'b0010});
    end
    @(posedge clk); #1;
    total++;
    if (OUT_VALID !== 1'b0) begin
      bad++; $display("FAIL b2b_end got=%b req=%b", OUT_VALID, 1'b0);
    end
  endtask

  task automatic test_mul;
    int busy_bad;
    busy_bad = 0;
    issue(12'h040, 12'h040, 3'b110);
    // Hold an ADD request throughout the multiply; it must be ignored.
    for (int i = 0; i < W; i++) begin
      if (IN_READY !== 1'b0 || OUT_VALID !== 1'b0) busy_bad++;
      DATA_A = 12'h001; DATA_B = 12'h001; control = 3'b000; IN_VALID = 1'b1;
      @(posedge clk); #1;
    end
    IN_VALID = 1'b0;
    total++;
    if (busy_bad !== 0) begin
      bad++; $display("FAIL mul_busy got=%0d req=%0d", busy_bad, 0);
    end
    total++;
    if ({IN_READY, OUT_VALID, OUT, CO, OVF, N, Z} !== {2'b11, 12'h000, 4'b0101}) begin
      bad++; $display("FAIL mul_ovf got=%h req=%h", {IN_READY, OUT_VALID, OUT, CO, OVF, N, Z}, {2'b11, 12'h000, 4'b0101});
    end
    @(posedge clk); #1;
    total++;
    if ({OUT_VALID, OUT} !== {1'b0, 12'h000}) begin
      bad++; $display("FAIL mul_no_queue got=%h req=%h", {OUT_VALID, OUT}, {1'b0, 12'h000});
    end
    issue(12'h00F, 12'h011, 3'b110);
    repeat (W - 1) @(posedge clk);
    #1;
    total++;
    if (OUT_VALID !== 1'b0) begin
      bad++; $display("FAIL mul_early got=%b req=%b", OUT_VALID, 1'b0);
    end
    @(posedge clk); #1;
    total++;
    if ({OUT_VALID, OUT, CO, OVF, N, Z} !== {1'b1, 12'h0FF, 4'b0000}) begin
      bad++; $display("FAIL mul_small got=%h req=%h", {OUT_VALID, OUT, CO, OVF, N, Z}, {1'b1, 12'h0FF, 4'b0000});
    end
  endtask

  task automatic test_mul_reset;
    int pulses;
    pulses = 0;
    issue(12'h003, 12'h005, 3'b110);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({OUT, OUT_VALID, CO, OVF, N, Z, IN_READY} !== {12'h000, 6'b000001}) begin
      bad++; $display("FAIL mul_reset got=%h req=%h", {OUT, OUT_VALID, CO, OVF, N, Z, IN_READY}, {12'h000, 6'b000001});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (OUT_VALID !== 1'b0) pulses++;
    end
    total++;
    if (pulses !== 0 || IN_READY !== 1'b1) begin
      bad++; $display("FAIL mul_abort got=%0d/%b req=0/1", pulses, IN_READY);
    end
    issue(12'h002, 12'h003, 3'b110);
    repeat (W) @(posedge clk);
    #1;
    total++;
    if ({OUT_VALID, OUT} !== {1'b1, 12'h006}) begin
      bad++; $display("FAIL mul_after_reset got=%h req=%h", {OUT_VALID, OUT}, {1'b1, 12'h006});
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_adc;
    test_cmp;
    test_back_to_back;
    test_mul;
    test_mul_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter W, default 12, operand/result width in bits; legal range 4..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 DATA_A  input  W  operand A, sampled on accept.
REQ-005 DATA_B  input  W  operand B, sampled on accept.
REQ-006 control  input  3  opcode, sampled on accept: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 XOR, 101 ADC, 110 MUL, 111 CMP.
REQ-007 IN_VALID  input  1  operation request.
REQ-008 IN_READY  output  1  block can accept a request this cycle.
REQ-009 OUT  output  W  registered result.
REQ-010 OUT_VALID  output  1  one-cycle pulse, result/flags updated this cycle.
REQ-011 CO, OVF, N, Z  output  1 each  registered carry, signed overflow, negative, zero flags.

Function
REQ-012 Accept occurs on a rising edge with IN_VALID=1 and IN_READY=1; operands and opcode are captured internally; inputs are don't-care at all other times.
REQ-013 FSM states IDLE and MULT; IN_READY=1 exactly in IDLE.
REQ-014 IDLE, accept of non-MUL opcode: stay IDLE; OUT/flags written and OUT_VALID=1 in the following cycle (latency 1); back-to-back accepts every cycle are supported.
REQ-015 IDLE, accept of MUL: go to MULT; shift-add multiplier runs W cycles; OUT/flags written and OUT_VALID=1 exactly W cycles after the accept edge, same edge returns to IDLE.
REQ-016 IN_VALID in MULT is ignored (no accept, no queuing).
REQ-017 No output backpressure; OUT_VALID is high for exactly one cycle per accepted operation.
REQ-018 OUT and flags hold their last written values until the next result.
REQ-019 ADD: OUT=(A+B) mod 2^W; CO=carry out of bit W-1; OVF=two's-complement overflow.
REQ-020 SUB: OUT=(A+~B+1) mod 2^W; CO=carry out of that sum (1 = no borrow, A>=B unsigned); OVF=signed overflow of A-B.
REQ-021 ADC: OUT=(A+B+C) mod 2^W where C is the current registered CO; CO/OVF as ADD.
REQ-022 AND/ORR/XOR: bitwise; CO=0, OVF=0.
REQ-023 MUL: unsigned; OUT=low W bits of A*B; OVF=1 if any high W bits of the 2W-bit product nonzero; CO=0.
REQ-024 CMP: computes SUB; CO/OVF/N/Z updated as SUB; OUT unchanged; OUT_VALID pulses.
REQ-025 All opcodes: N=result bit W-1, Z=1 iff result all zero (for CMP, the difference, not OUT).
REQ-026 Multiplier iteration counter is ceil(log2(W+1)) bits and reloads on every MUL accept.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE, OUT=0, CO=0, OVF=0, N=0, Z=0, OUT_VALID=0, counter=0, internal operand/product registers=0; IN_READY=1 while rst_n=0.
REQ-028 Reset during MULT aborts the multiply; no OUT_VALID is produced for it after release.
REQ-029 First accept is possible on the first rising edge after rst_n deasserts.

Verification (W=12)
REQ-030 ADD A=0x800, B=0x800 -> next cycle OUT=0x000, CO=1, OVF=1, N=0, Z=1, OUT_VALID pulse.
REQ-031 SUB A=0x005, B=0x007 -> OUT=0xFFE, CO=0, OVF=0, N=1, Z=0; then ADC A=0x001, B=0x001 -> OUT=0x002 (C=0); after ADD 0xFFF+0x001 (CO=1), ADC 0x001+0x001 -> OUT=0x003.
REQ-032 MUL A=0x040, B=0x040 -> IN_READY=0 for 12 cycles, IN_VALID ignored meanwhile, OUT_VALID exactly 12 cycles after accept, OUT=0x000, OVF=1, Z=1, CO=0; MUL 0x00F*0x011 -> OUT=0x0FF, OVF=0.
REQ-033 OUT=0x123 from prior op, then CMP A=0x010, B=0x010 -> OUT stays 0x123, Z=1, CO=1, N=0, OUT_VALID pulse.
REQ-034 Back-to-back AND/ORR/XOR with A=0xF0F, B=0x0FF on consecutive cycles -> OUT 0x00F, 0xFFF, 0xFF0 on consecutive cycles, CO=OVF=0.
REQ-035 Assert rst_n=0 at cycle 5 of a MUL -> all outputs 0, IN_READY=1 immediately; after release no OUT_VALID until a new accept.
